// File: rtl/seq_detect_mealy.sv
// seq_detect_mealy: runtime-programmable N-bit Mealy sequence detector
// with overlap/non-overlap modes, input enable and saturating match count.
module seq_detect_mealy #(
  parameter int             N           = 4,
  parameter logic [N-1:0]   DEFAULT_PAT = 4'b1011,
  parameter int             CW          = 8,
  parameter int             SW          = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in,
  input  logic          overlap,
  input  logic          load,
  input  logic [N-1:0]  pat_in,
  output logic [N-1:0]  pattern,
  output logic [SW-1:0] state,
  output logic          out,
  output logic [CW-1:0] match_count
);

  localparam int MW = $clog2(N + 1);

  logic [N-1:0]  r_pat;
  logic [SW-1:0] r_state;
  logic [CW-1:0] r_cnt;

  logic [MW-1:0] w_m;
  logic [SW-1:0] w_border;
  logic          w_hit;

  // Longest pattern prefix that is a suffix of (prefix k, then b).
  // The first k accepted bits are known to equal the pattern prefix,
  // so the candidate string is rebuilt from the pattern itself.
  function automatic logic [MW-1:0] f_next_len(
    input logic [SW-1:0] k,
    input logic          b,
    input logic [N-1:0]  p
  );
    logic [N:0]    s;
    logic [N:0]    pj;
    logic [N:0]    msk;
    logic [MW-1:0] m;
    s = {1'b0, p} >> (N - int'(k));
    s = {s[N-1:0], b};
    m = '0;
    for (int j = 1; j <= N; j++) begin
      pj  = {1'b0, p} >> (N - j);
      msk = {(N+1){1'b1}} >> (N + 1 - j);
      if (j <= int'(k) + 1 && (s & msk) == pj)
        m = MW'(j);
    end
    return m;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic logic [SW-1:0] f_border(
    input logic [N-1:0] p
  );
    logic [N-1:0]  msk;
    logic [SW-1:0] bd;
    bd = '0;
    for (int b = 1; b < N; b++) begin
      msk = {N{1'b1}} >> (N - b);
      if ((p & msk) == (p >> (N - b)))
        bd = SW'(b);
    end
    return bd;
  endfunction

  assign w_m      = f_next_len(r_state, in, r_pat);
  assign w_hit    = (w_m == MW'(N));
  assign w_border = f_border(r_pat);

  // Match flag is combinational so it lines up with the final bit.
  assign out = en & ~load & ~reset & w_hit;

  // Pattern register, prefix-length state and saturating counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat   <= DEFAULT_PAT;
      r_state <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_pat   <= pat_in;
      r_state <= '0;
      r_cnt   <= '0;
    end else if (en) begin
      if (w_hit) begin
        r_state <= overlap ? w_border : '0;
        if (r_cnt != '1)
          r_cnt <= r_cnt + CW'(1);
      end else begin
        r_state <= w_m[SW-1:0];
      end
    end
  end

  assign pattern     = r_pat;
  assign state       = r_state;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_seq_detect_mealy.sv
// tb_seq_detect_mealy: directed tests for seq_detect_mealy.
// A second instance with a 2-bit counter covers saturation.
module tb_seq_detect_mealy;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       in;
  logic       overlap;
  logic       load;
  logic [3:0] pat_in;

  logic [3:0] pattern;
  logic [1:0] state;
  logic       out;
  logic [7:0] match_count;

  logic [3:0] s_pattern;
  logic [1:0] s_state;
  logic       s_out;
  logic [1:0] s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_mealy u_dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in          (in),
    .overlap     (overlap),
    .load        (load),
    .pat_in      (pat_in),
    .pattern     (pattern),
    .state       (state),
    .out         (out),
    .match_count (match_count)
  );

  seq_detect_mealy #(.CW(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .in          (in),
    .overlap     (overlap),
    .load        (load),
    .pat_in      (pat_in),
    .pattern     (s_pattern),
    .state       (s_state),
    .out         (s_out),
    .match_count (s_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    en    = 1'b0;
    load  = 1'b0;
    in    = 1'b0;
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (state !== 2'd0 || pattern !== 4'b1011 ||
        match_count !== 8'd0 || out !== 1'b0) begin
      errors++;
      $display("FAIL rst_init: st=%0d pat=%b cnt=%0d out=%b want 0 1011 0 0",
               state, pattern, match_count, out);
    end
    reset = 1'b0;
    tick;
    en = 1'b1; in = 1'b1; tick;
    in = 1'b0; tick;
    in = 1'b1; tick;
    in = 1'b1;
    #1;
    checks++;
    if (out !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_out: got %b want 1", out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0 || state !== 2'd0 ||
        pattern !== 4'b1011 || match_count !== 8'd0) begin
      errors++;
      $display("FAIL rst_async: out=%b st=%0d pat=%b cnt=%0d want 0 0 1011 0",
               out, state, pattern, match_count);
    end
    reset = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle_out c%0d: got %b want 0", i, out);
      end
      tick;
      checks++;
      if (state !== 2'd0) begin
        errors++;
        $display("FAIL rst_idle_st c%0d: got %0d want 0", i, state);
      end
    end
  endtask

  task automatic test_overlap;
    logic       bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic       exo  [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic [1:0] exs  [7] = '{1, 2, 3, 1, 2, 3, 1};
    do_reset;
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; in = bits[i];
      #1;
      checks++;
      if (out !== exo[i]) begin
        errors++;
        $display("FAIL ovl_out b%0d: got %b want %b", i + 1, out, exo[i]);
      end
      tick;
      checks++;
      if (state !== exs[i]) begin
        errors++;
        $display("FAIL ovl_st b%0d: got %0d want %0d", i + 1, state, exs[i]);
      end
    end
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL ovl_cnt: got %0d want 2", match_count);
    end
  endtask

  task automatic test_nonoverlap;
    logic       bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic       exo  [7] = '{0, 0, 0, 1, 0, 0, 0};
    logic [1:0] exs  [7] = '{1, 2, 3, 0, 0, 1, 1};
    do_reset;
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; in = bits[i];
      #1;
      checks++;
      if (out !== exo[i]) begin
        errors++;
        $display("FAIL novl_out b%0d: got %b want %b", i + 1, out, exo[i]);
      end
      tick;
      checks++;
      if (state !== exs[i]) begin
        errors++;
        $display("FAIL novl_st b%0d: got %0d want %0d", i + 1, state, exs[i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL novl_cnt: got %0d want 1", match_count);
    end
  endtask

  task automatic test_en_gap;
    logic       bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic       ens  [7] = '{1, 1, 1, 0, 1, 1, 1};
    logic       exo  [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic [1:0] exs  [7] = '{1, 2, 3, 3, 2, 3, 1};
    do_reset;
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) begin
      en = ens[i]; in = bits[i];
      #1;
      checks++;
      if (out !== exo[i]) begin
        errors++;
        $display("FAIL gap_out c%0d: got %b want %b", i + 1, out, exo[i]);
      end
      tick;
      checks++;
      if (state !== exs[i]) begin
        errors++;
        $display("FAIL gap_st c%0d: got %0d want %0d", i + 1, state, exs[i]);
      end
    end
    checks++;
    if (match_count !== 8'd1) begin
      errors++;
      $display("FAIL gap_cnt: got %0d want 1", match_count);
    end
  endtask

  task automatic test_load;
    logic       bits [6] = '{1, 0, 1, 1, 0, 1};
    logic       exo  [7] = '{0, 0, 0, 1, 1, 1, 1};
    logic [1:0] exs  [7] = '{1, 2, 3, 3, 3, 3, 3};
    do_reset;
    overlap = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = 1'b1; in = bits[i]; tick;
    end
    checks++;
    if (state !== 2'd3 || match_count !== 8'd1) begin
      errors++;
      $display("FAIL ld_pre: st=%0d cnt=%0d want 3 1", state, match_count);
    end
    load = 1'b1; pat_in = 4'b1111; en = 1'b1; in = 1'b1;
    #1;
    checks++;
    if (out !== 1'b0) begin
      errors++;
      $display("FAIL ld_out: got %b want 0", out);
    end
    tick;
    load = 1'b0;
    checks++;
    if (state !== 2'd0 || match_count !== 8'd0 || pattern !== 4'b1111) begin
      errors++;
      $display("FAIL ld_post: st=%0d cnt=%0d pat=%b want 0 0 1111",
               state, match_count, pattern);
    end
    for (int i = 0; i < 7; i++) begin
      en = 1'b1; in = 1'b1;
      #1;
      checks++;
      if (out !== exo[i]) begin
        errors++;
        $display("FAIL ld1_out b%0d: got %b want %b", i + 1, out, exo[i]);
      end
      tick;
      checks++;
      if (state !== exs[i]) begin
        errors++;
        $display("FAIL ld1_st b%0d: got %0d want %0d", i + 1, state, exs[i]);
      end
    end
    checks++;
    if (match_count !== 8'd4) begin
      errors++;
      $display("FAIL ld1_cnt: got %0d want 4", match_count);
    end
  endtask

  task automatic test_saturation;
    logic [1:0] exc;
    do_reset;
    overlap = 1'b1;
    load = 1'b1; pat_in = 4'b1111; en = 1'b1; in = 1'b0;
    tick;
    load = 1'b0;
    checks++;
    if (s_pattern !== 4'b1111 || s_count !== 2'd0) begin
      errors++;
      $display("FAIL sat_load: pat=%b cnt=%0d want 1111 0", s_pattern, s_count);
    end
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; in = 1'b1;
      #1;
      checks++;
      if (s_out !== (i >= 3)) begin
        errors++;
        $display("FAIL sat_out b%0d: got %b want %b", i + 1, s_out, i >= 3);
      end
      tick;
      exc = (i < 3) ? 2'd0 : (i - 2 >= 3) ? 2'd3 : 2'(i - 2);
      checks++;
      if (s_count !== exc) begin
        errors++;
        $display("FAIL sat_cnt b%0d: got %0d want %0d", i + 1, s_count, exc);
      end
    end
    in = 1'b0; tick;
    in = 1'b1; tick;
    tick;
    checks++;
    if (s_state !== 2'd2) begin
      errors++;
      $display("FAIL sat_pre_rst: st=%0d want 2", s_state);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (s_state !== 2'd0 || s_out !== 1'b0 ||
        s_count !== 2'd0 || s_pattern !== 4'b1011) begin
      errors++;
      $display("FAIL sat_rst: st=%0d out=%b cnt=%0d pat=%b want 0 0 0 1011",
               s_state, s_out, s_count, s_pattern);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; in = 1'b0;
    overlap = 1'b0; load = 1'b0; pat_in = 4'b0000;
    tick;
    test_reset;
    test_overlap;
    test_nonoverlap;
    test_en_gap;
    test_load;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_mealy.md
# seq_detect_mealy

Parametrised, runtime-programmable Mealy sequence detector for a serial bit stream. It generalises the fixed 2-bit-state detector to patterns of N bits. It adds a loadable pattern, overlapping and non-overlapping match modes, an input enable and a saturating match counter. It sits directly on a serial input line and flags each completed pattern in the same cycle as the pattern's final bit.

## Interface
Parameters:
- N, 4: pattern length in bits, legal range 2..16.
- DEFAULT_PAT, 4'b1011: pattern loaded at reset, N bits wide.
- CW, 8: width of the match counter.
- SW, $clog2(N): width of the state output. It holds values 0..N-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  accept `in` this cycle. When low, the cycle is ignored.
- in  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- load  in  1  one-cycle pulse that loads `pat_in` into the pattern register.
- pat_in  in  N  new pattern.
- pattern  out  N  current pattern register.
- state  out  SW  current FSM state, registered.
- out  out  1  Mealy match flag, combinational.
- match_count  out  CW  number of matches since reset or load, saturating.

## Operation
- Pattern bit order:
  - pattern[N-1] is the first bit expected on `in`; pattern[0] is the last.
  - Example: with 1011, the input order is 1, 0, 1, 1.
- State meaning: `state` = k is the length of the longest suffix of accepted bits that equals the first k bits of the pattern. k is always in 0..N-1.
- Next-state function, applied when en=1:
  - Let m be the longest j ≤ N such that (prefix k followed by `in`) ends with pattern prefix j.
  - If m < N: next state = m and out = 0.
  - If m = N: out = 1 and match_count is incremented.
  - On a match with overlap=1: next state = longest proper prefix of the pattern that is also a suffix of the pattern (its border, length < N).
  - On a match with overlap=0: next state = 0.
- Mealy output: out = en & ~load & (m == N). It is a combinational function of state, in, pattern, en and load.
- en=0: state and match_count hold, and out = 0.
- Load (load=1):
  - pattern <= pat_in, state <= 0, match_count <= 0, out = 0.
  - `in` is ignored that cycle, even with en=1.
  - load has priority over en.
- `overlap` is sampled only on the cycle that completes a match. It may change between matches.
- match_count saturates at 2^CW-1 and does not wrap. `out` still pulses when the counter is saturated.
- Degenerate patterns are legal and resolved by the same rule. Example: all-ones with overlap=1 has border N-1, so once primed it matches on every 1.

## Timing
- Reset (asynchronous, effective immediately on assertion):
  - state = 0, pattern = DEFAULT_PAT, match_count = 0.
  - out = 0 while reset is high.
  - Reset mid-stream discards all partial-match progress.
- Sampling: `in`, `en`, `load`, `pat_in` and `overlap` are sampled on the rising edge of clk.
  - state, pattern and match_count update at that edge.
- Latency:
  - `out` goes high combinationally in the cycle the final pattern bit is present on `in`, before the capturing edge.
  - match_count shows the increment one cycle later.
- No handshake and no backpressure: one bit per cycle when en=1.
- Deassertion of reset must meet recovery/removal to clk. The first accepted bit is on the first edge with reset low.

## Test plan
- Reset and defaults: assert reset mid-cycle -> state=0, pattern=4'b1011, match_count=0, out=0 immediately. Release reset and hold en=0 for 3 cycles -> state stays 0 and out stays 0.
- Overlap mode: N=4, pattern 1011, overlap=1, stream 1,0,1,1,0,1,1 -> state sequence 1,2,3,1,2,3,1. out=1 on bits 4 and 7. match_count=2.
- Non-overlap mode: same stream with overlap=0 -> out=1 on bit 4 only. States after bit 4 are 0,0,1,1. match_count=1.
- Enable gaps and KMP fallback:
  - Stream 1,0,1,0,1,1 with en=0 for one cycle between bits 3 and 4 -> states 1,2,3,(hold 3),2,3,match.
  - out=1 only on bit 6; out=0 during the en=0 cycle.
- Load priority and reprogramming: in state 3, assert load=1, pat_in=4'b1111, en=1, in=1 -> no match, state=0, match_count=0, pattern=1111. Then seven 1s with overlap=1 -> out=1 on bits 4 to 7, match_count=4.
- Saturation and reset mid-operation: CW=2, pattern 1111, overlap=1, ten 1s -> match_count sticks at 3 while out continues to pulse. Assert reset at state 2 -> state=0 and out=0 asynchronously.
